sd_spi: RTL and testbench

SPI master engine for the SD card slot, sitting behind the AVR port registers at 0x39/0x3A. It executes the 2-bit commands latched by the port logic and shifts one byte per transfer: the byte written to SD-DAT goes out, and the byte received comes back to SD-DAT. It reports progress through the SD-BSY and SD-TIME bits of the STATUS port. It drives the physical card pins CS, SCLK and MOSI, and samples MISO.

---
 rtl/sd_spi_pkg.sv | 34 +++
 rtl/sd_spi_clkgen.sv | 49 ++++
 rtl/sd_spi.sv | 173 +++++++++++++++++
 tb/tb_sd_spi.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// ============================================================================
// Module : sd_spi_pkg
// Brief  : Shared command codes, FSM state encoding and constants for sd_spi.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sd_spi_pkg;

  typedef enum logic [1:0] {
    SD_CMD_INIT     = 2'd0,
    SD_CMD_XFER     = 2'd1,
    SD_CMD_SELECT   = 2'd2,
    SD_CMD_DESELECT = 2'd3
  } sd_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } sd_state_e;

  localparam int unsigned c_INIT_PULSES = 80;
  localparam int unsigned c_BITS        = 8;

  // Index of the final SCLK pulse for the active serial phase.
  function automatic logic [6:0] last_pulse(input sd_state_e st);
    return (st == ST_INIT) ? 7'(c_INIT_PULSES - 1) : 7'(c_BITS - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_spi_clkgen.sv
// ============================================================================
// Module : sd_spi_clkgen
// Brief  : SCLK half-period divider; emits tick_rise/tick_fall one cycle
//          before the corresponding SCLK edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             spi_sclk
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_half_end;

  assign w_half_end = run && (r_cnt == '0);
  assign tick_rise  = w_half_end && !r_sclk;
  assign tick_fall  = w_half_end && r_sclk;
  assign spi_sclk   = r_sclk;

  // While stopped the counter sits at the reload value, so the first half
  // period after start-up is a full DIV cycles long.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!run) begin
      r_cnt  <= div - DIV_W'(1);
      r_sclk <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt  <= div - DIV_W'(1);
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt - DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sd_spi.sv
// ============================================================================
// Module : sd_spi
// Brief  : SD-card SPI master: INIT / XFER / SELECT / DESELECT engine.
//          Optional CS-idle watchdog built when SD_TIMEOUT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_spi
  import sd_spi_pkg::*;
#(
  parameter int          INIT_DIV       = 64,
  parameter int          SPI_DIV        = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] sd_cmd,
  input  logic       sd_signal,
  input  logic [7:0] sd_out,
  output logic [7:0] sd_din,
  output logic       sd_busy,
  output logic       sd_timeout,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int c_DIV_W = $clog2((INIT_DIV > SPI_DIV ? INIT_DIV : SPI_DIV) + 1);

  sd_state_e          r_state;
  sd_state_e          w_state_next;
  logic               r_sig;
  logic               r_armed;
  logic               w_accept;
  logic [7:0]         r_shift;
  logic               r_mosi;
  logic               r_cs;
  logic [7:0]         r_din;
  logic               r_busy;
  logic               r_load_din;
  logic [6:0]         r_pulse;
  logic               w_last;
  logic               w_run;
  logic               w_tick_rise;
  logic               w_tick_fall;
  logic [c_DIV_W-1:0] w_div;

  // r_armed keeps a strobe level held high through reset from firing.
  assign w_accept = sd_signal && !r_sig && r_armed && (r_state == ST_IDLE);
  assign w_run    = (r_state == ST_INIT) || (r_state == ST_SHIFT);
  assign w_last   = (r_pulse == last_pulse(r_state));
  assign w_div    = (w_state_next == ST_INIT) ? c_DIV_W'(INIT_DIV) : c_DIV_W'(SPI_DIV);

  sd_spi_clkgen #(
    .DIV_W(c_DIV_W)
  ) u_clkgen (
    .clock    (clock),
    .reset    (reset),
    .div      (w_div),
    .run      (w_run),
    .tick_rise(w_tick_rise),
    .tick_fall(w_tick_fall),
    .spi_sclk (spi_sclk)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (sd_cmd_e'(sd_cmd))
            SD_CMD_INIT: w_state_next = ST_INIT;
            SD_CMD_XFER: w_state_next = ST_SHIFT;
            default:     w_state_next = ST_DONE;
          endcase
        end
      end
      ST_INIT, ST_SHIFT: begin
        if (w_tick_fall && w_last) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sig      <= 1'b0;
      r_armed    <= 1'b0;
      r_shift    <= 8'hFF;
      r_mosi     <= 1'b1;
      r_cs       <= 1'b1;
      r_din      <= 8'hFF;
      r_busy     <= 1'b0;
      r_load_din <= 1'b0;
      r_pulse    <= '0;
    end else begin
      r_sig  <= sd_signal;
      r_busy <= (w_state_next != ST_IDLE);
      if (!sd_signal) r_armed <= 1'b1;

      if (w_accept) begin
        r_pulse    <= '0;
        r_load_din <= (sd_cmd_e'(sd_cmd) == SD_CMD_XFER);
        case (sd_cmd_e'(sd_cmd))
          SD_CMD_INIT: begin
            r_cs   <= 1'b1;
            r_mosi <= 1'b1;
          end
          SD_CMD_XFER: begin
            r_shift <= sd_out;
            r_mosi  <= sd_out[7];
          end
          SD_CMD_SELECT: r_cs <= 1'b0;
          default:       r_cs <= 1'b1;
        endcase
      end else begin
        // One register serves as both TX and RX: MISO enters at the bottom
        // as each TX bit leaves the top.
        if (w_tick_rise && (r_state == ST_SHIFT))
          r_shift <= {r_shift[6:0], spi_miso};
        if (w_tick_fall) begin
          if (w_last) begin
            r_mosi <= 1'b1;
          end else begin
            r_pulse <= r_pulse + 7'd1;
            if (r_state == ST_SHIFT) r_mosi <= r_shift[7];
          end
        end
        if ((r_state == ST_DONE) && r_load_din) r_din <= r_shift;
      end
    end
  end

  assign sd_din   = r_din;
  assign sd_busy  = r_busy;
  assign spi_cs   = r_cs;
  assign spi_mosi = r_mosi;

`ifdef SD_TIMEOUT_EN
  logic [23:0] r_idle_cnt;
  logic        r_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_accept || r_cs) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if ((r_state == ST_IDLE) && (r_idle_cnt != TIMEOUT_CYCLES)) begin
      r_idle_cnt <= r_idle_cnt + 24'd1;
      r_timeout  <= ((r_idle_cnt + 24'd1) == TIMEOUT_CYCLES);
    end
  end

  assign sd_timeout = r_timeout;
`else
  // Watchdog not built; the limit parameter has no effect in this build.
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign sd_timeout       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sd_spi.sv
// ============================================================================
// Module : tb_sd_spi
// Brief  : Randomised self-checking bench for sd_spi with an SD-card model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sd_spi;

  localparam int INIT_DIV = 4;
  localparam int SPI_DIV  = 2;
  localparam int WD_LIMIT = 10;
`ifdef SD_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sd_cmd = 2'd0;
  logic       sd_signal = 1'b0;
  logic [7:0] sd_out = 8'h00;
  logic [7:0] sd_din;
  logic       sd_busy;
  logic       sd_timeout;
  logic       spi_cs;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  sd_spi #(
    .INIT_DIV      (INIT_DIV),
    .SPI_DIV       (SPI_DIV),
    .TIMEOUT_CYCLES(24'(WD_LIMIT))
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sd_cmd    (sd_cmd),
    .sd_signal (sd_signal),
    .sd_out    (sd_out),
    .sd_din    (sd_din),
    .sd_busy   (sd_busy),
    .sd_timeout(sd_timeout),
    .spi_cs    (spi_cs),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SD-card model: presents MISO bits MSB first, advancing on SCLK falls,
  // and records what it sees on every SCLK rise.
  bit         loopback = 1'b0;
  logic [7:0] card_byte = 8'hFF;
  int         card_idx = 0;
  int         rises = 0;
  int         cs_hi_rises = 0;
  int         mosi_low_rises = 0;
  logic [7:0] rx_mosi = 8'h00;

  always @(posedge spi_sclk) begin
    rises++;
    rx_mosi = {rx_mosi[6:0], spi_mosi};
    if (spi_cs) cs_hi_rises++;
    if (!spi_mosi) mosi_low_rises++;
  end

  always @(negedge spi_sclk) card_idx++;

  assign spi_miso = loopback ? spi_mosi
                  : ((card_idx < 8) ? card_byte[3'(7 - card_idx)] : 1'b1);

  // Reference state of the card-facing registers.
  logic [7:0] m_din = 8'hFF;
  logic       m_cs  = 1'b1;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one command from a quiet IDLE state and check the whole transaction.
  task automatic run_cmd(input logic [1:0] cmd, input logic [7:0] dout,
                         input logic [7:0] miso_b, input bit loop,
                         input bit restrobe, input string tag);
    int exp_dur;
    int exp_rises;
    int dur;
    card_byte = miso_b; card_idx = 0; loopback = loop;
    rises = 0; cs_hi_rises = 0; mosi_low_rises = 0; rx_mosi = 8'h00;
    sd_cmd = cmd; sd_out = dout; sd_signal = 1'b1;
    case (cmd)
      2'd0: begin exp_dur = 160 * INIT_DIV + 1; exp_rises = 80; m_cs = 1'b1; end
      2'd1: begin exp_dur = 16 * SPI_DIV + 1; exp_rises = 8; m_din = loop ? dout : miso_b; end
      2'd2: begin exp_dur = 1; exp_rises = 0; m_cs = 1'b0; end
      default: begin exp_dur = 1; exp_rises = 0; m_cs = 1'b1; end
    endcase
    step();
    check_eq({tag, " busy@A+1"}, sd_busy, 1);
    check_eq({tag, " cs@A+1"}, spi_cs, m_cs);
    check_eq({tag, " timeout@A+1"}, sd_timeout, 0);
    sd_signal = 1'b0;
    dur = 0;
    while (sd_busy === 1'b1 && dur < exp_dur + 100) begin
      dur++;
      if (restrobe && dur == 6) sd_signal = 1'b1;
      step();
    end
    check_eq({tag, " busy_cycles"}, dur, exp_dur);
    check_eq({tag, " din"}, sd_din, m_din);
    check_eq({tag, " cs"}, spi_cs, m_cs);
    check_eq({tag, " sclk_rises"}, rises, exp_rises);
    check_eq({tag, " idle_sclk"}, spi_sclk, 0);
    check_eq({tag, " idle_mosi"}, spi_mosi, 1);
    if (cmd == 2'd1) check_eq({tag, " mosi_byte"}, rx_mosi, dout);
    if (cmd == 2'd0) begin
      check_eq({tag, " cs_high_rises"}, cs_hi_rises, 80);
      check_eq({tag, " mosi_low_rises"}, mosi_low_rises, 0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int busy_seen;
    int guard;
    logic [1:0] rc;
    logic [7:0] ro;
    logic [7:0] rm;

    // Reset with the strobe line held high throughout.
    sd_signal = 1'b1;
    repeat (3) step();
    check_eq("rst din", sd_din, 8'hFF);
    check_eq("rst busy", sd_busy, 0);
    check_eq("rst timeout", sd_timeout, 0);
    check_eq("rst cs", spi_cs, 1);
    check_eq("rst sclk", spi_sclk, 0);
    check_eq("rst mosi", spi_mosi, 1);
    reset = 1'b0;
    busy_seen = 0;
    repeat (8) begin step(); if (sd_busy) busy_seen++; end
    check_eq("held_strobe no_fire", busy_seen, 0);
    sd_signal = 1'b0;
    repeat (2) step();

    run_cmd(2'd2, 8'h00, 8'hFF, 1'b0, 1'b0, "select");
    run_cmd(2'd1, 8'hA5, 8'h00, 1'b1, 1'b0, "xfer_loop_a5");
    run_cmd(2'd1, 8'hFF, 8'h3C, 1'b0, 1'b0, "xfer_miso_3c");
    check_eq("xfer_miso_3c mosi_low", mosi_low_rises, 0);
    run_cmd(2'd0, 8'h00, 8'hFF, 1'b0, 1'b0, "init");
    run_cmd(2'd2, 8'h00, 8'hFF, 1'b0, 1'b0, "select2");

    // Second strobe mid-transfer must be dropped, and holding it high after.
    run_cmd(2'd1, 8'h5A, 8'h00, 1'b1, 1'b1, "xfer_restrobe");
    busy_seen = 0;
    repeat (40) begin step(); if (sd_busy) busy_seen++; end
    check_eq("restrobe no_second_cmd", busy_seen, 0);
    sd_signal = 1'b0;
    repeat (2) step();

    // CS-idle watchdog: count starts in the first IDLE cycle after SELECT.
    run_cmd(2'd2, 8'h00, 8'hFF, 1'b0, 1'b0, "wd_select");
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 9)  check_eq("wd k9", sd_timeout, 0);
      if (k == 10) check_eq("wd k10", sd_timeout, WD_ON);
      if (k == 20) check_eq("wd k20_sat", sd_timeout, WD_ON);
    end
    run_cmd(2'd1, 8'h81, 8'h7E, 1'b0, 1'b0, "wd_xfer");
    run_cmd(2'd3, 8'h00, 8'hFF, 1'b0, 1'b0, "wd_deselect");
    busy_seen = 0;
    repeat (20) begin step(); if (sd_timeout) busy_seen++; end
    check_eq("wd deselect_quiet", busy_seen, 0);

    // Randomised command stream against the reference model.
    for (int i = 0; i < 24; i++) begin
      rc = 2'($urandom_range(0, 3));
      if (i % 3 != 2 && rc == 2'd0) rc = 2'd1;
      ro = 8'($urandom);
      rm = 8'($urandom);
      run_cmd(rc, ro, rm, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 3)) step();
    end

    // Reset in the middle of a transfer.
    run_cmd(2'd2, 8'h00, 8'hFF, 1'b0, 1'b0, "pre_rst_select");
    card_idx = 0; loopback = 1'b1; rises = 0;
    sd_cmd = 2'd1; sd_out = 8'hC3; sd_signal = 1'b1;
    step();
    sd_signal = 1'b0;
    guard = 0;
    while (rises < 4 && guard < 200) begin step(); guard++; end
    check_eq("rst_mid reached_bit4", rises, 4);
    reset = 1'b1;
    step();
    check_eq("rst_mid cs", spi_cs, 1);
    check_eq("rst_mid sclk", spi_sclk, 0);
    check_eq("rst_mid mosi", spi_mosi, 1);
    check_eq("rst_mid busy", sd_busy, 0);
    check_eq("rst_mid din", sd_din, 8'hFF);
    reset = 1'b0;
    m_din = 8'hFF;
    m_cs  = 1'b1;
    repeat (3) step();
    run_cmd(2'd1, 8'h69, 8'h00, 1'b1, 1'b0, "post_rst_xfer");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
